// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, debounce, one code per press.
// Define KEYPAD_REPEAT_EN to build the held-key auto-repeat logic.
module keypad_scanner #(
  parameter int SCAN_DIV           = 100000,
  parameter int DEBOUNCE_SCANS     = 4,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_row_n,
  output logic [3:0] o_col_n,
  output logic [3:0] o_key,
  output logic       o_valid,
  output logic       o_pressed
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 ||
      REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [15:0]   r_snap;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic [3:0]    r_key;
  logic          r_valid;
  logic          r_pressed;

  logic          w_sample;
  logic          w_eval;
  logic [15:0]   w_cur;
  logic [15:0]   w_scan;
  logic          w_none;
  logic          w_single;
  logic [3:0]    w_idx;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_cand_nxt;
  logic          w_accept;
  logic          w_rpt_pulse;

  assign w_sample = (r_dwell == DWELL_MAX);
  assign w_eval   = w_sample && (r_col == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_dwell <= '0;
      r_col   <= 2'd0;
      r_snap  <= '0;
    end else begin
      r_sync1 <= i_row_n;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= r_col + 2'd1;
        r_snap  <= w_eval ? 16'h0 : w_scan;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Current column is merged in so the last column counts in its own scan.
  always_comb begin
    w_cur = '0;
    if (w_sample) begin
      for (int r = 0; r < 4; r++) begin
        w_cur[{2'(r), r_col}] = ~r_sync2[r];
      end
    end
  end

  assign w_scan   = r_snap | w_cur;
  assign w_none   = (w_scan == 16'h0);
  assign w_single = !w_none &&
                    ((w_scan & (w_scan - 16'd1)) == 16'h0);

  always_comb begin
    w_idx = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (w_scan[i]) w_idx = 4'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (w_eval) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_idx;
            w_cnt_nxt  = CNT_ONE;
            if (DB_MAX == CNT_ONE) begin
              w_state_nxt = S_PRESSED;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && w_idx == r_cand) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt + CNT_ONE == DB_MAX) begin
              w_state_nxt = S_PRESSED;
              w_accept    = 1'b1;
            end
          end else if (w_single) begin
            w_cand_nxt = w_idx;
            w_cnt_nxt  = CNT_ONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (w_none) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = (DB_MAX == CNT_ONE) ? S_IDLE
                                              : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_none) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt + CNT_ONE == DB_MAX) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_PRESSED;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                        REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY_SCANS);
  localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE_SCANS);

  logic [RW-1:0] r_rpt;
  logic          r_rpt_first;
  logic          w_rpt_step;
  logic [RW-1:0] w_rpt_tgt;

  // Only scans that keep the key held advance; a release bounce freezes it.
  assign w_rpt_step  = w_eval && (r_state == S_PRESSED) &&
                       (w_state_nxt == S_PRESSED);
  assign w_rpt_tgt   = r_rpt_first ? RPT_DELAY : RPT_RATE;
  assign w_rpt_pulse = w_rpt_step && (r_rpt + RW'(1) == w_rpt_tgt);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_accept) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_rpt_pulse) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b0;
    end else if (w_rpt_step) begin
      r_rpt <= r_rpt + RW'(1);
    end
  end
`else
  assign w_rpt_pulse = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_key     <= 4'h0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_valid   <= w_accept | w_rpt_pulse;
      r_pressed <= (w_state_nxt == S_PRESSED) ||
                   (w_state_nxt == S_RELEASE);
      if (w_accept) r_key <= w_cand_nxt;
    end
  end

  assign o_col_n   = ~(4'b0001 << r_col);
  assign o_key     = r_key;
  assign o_valid   = r_valid;
  assign o_pressed = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, vector table, pulse scoreboard.
// One scan is 16 clocks with SCAN_DIV=4.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       valid;
  logic       pressed;
  logic [15:0] held;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] held;
    int          scans;
    int          pulses;
    logic        pressed;
    logic [3:0]  key;
  } vec_t;

  vec_t vecs[$];

  keypad_scanner #(
    .SCAN_DIV          (4),
    .DEBOUNCE_SCANS    (2),
    .REPEAT_DELAY_SCANS(3),
    .REPEAT_RATE_SCANS (2)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_row_n  (row_n),
    .o_col_n  (col_n),
    .o_key    (key),
    .o_valid  (valid),
    .o_pressed(pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A row reads low when a held key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(held[4*r +: 4] & ~col_n);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {28'h0, key}, 32'hFFFF_FFFF);
      end else begin
        chk("pulse_key", {28'h0, key}, {28'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic align();
    int n = 0;
    while (col_n != 4'b0111 && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (col_n != 4'b1110 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("align_timeout", {31'h0, n < 64}, 32'h1);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    for (int p = 0; p < v.pulses; p++) exp_q.push_back(v.key);
    held = v.held;
    repeat (16 * v.scans) @(negedge clk);
    #1;
    chk($sformatf("v%0d_pressed", idx), {31'h0, pressed},
        {31'h0, v.pressed});
    chk($sformatf("v%0d_key", idx), {28'h0, key}, {28'h0, v.key});
    chk($sformatf("v%0d_pending", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
`ifdef KEYPAD_REPEAT_EN
    vecs.push_back('{16'h0400, 2, 1, 1'b1, 4'hA});
    vecs.push_back('{16'h0400, 3, 1, 1'b1, 4'hA});
    vecs.push_back('{16'h0400, 2, 1, 1'b1, 4'hA});
    vecs.push_back('{16'h0400, 2, 1, 1'b1, 4'hA});
    vecs.push_back('{16'h0400, 2, 1, 1'b1, 4'hA});
    vecs.push_back('{16'h0400, 1, 0, 1'b1, 4'hA});
    vecs.push_back('{16'h0000, 2, 0, 1'b0, 4'hA});
`else
    vecs.push_back('{16'h0000,  2, 0, 1'b0, 4'h0});
    vecs.push_back('{16'h0200, 10, 1, 1'b1, 4'h9});
    vecs.push_back('{16'h0000,  1, 0, 1'b1, 4'h9});
    vecs.push_back('{16'h0000,  1, 0, 1'b0, 4'h9});
    vecs.push_back('{16'h1008,  4, 0, 1'b0, 4'h9});
    vecs.push_back('{16'h0008,  3, 1, 1'b1, 4'h3});
    vecs.push_back('{16'h1008,  4, 0, 1'b1, 4'h3});
    vecs.push_back('{16'h0000,  3, 0, 1'b0, 4'h3});
    vecs.push_back('{16'h0040,  3, 1, 1'b1, 4'h6});
    vecs.push_back('{16'h0000,  1, 0, 1'b1, 4'h6});
    vecs.push_back('{16'h0040,  2, 0, 1'b1, 4'h6});
    vecs.push_back('{16'h0000,  2, 0, 1'b0, 4'h6});
    vecs.push_back('{16'h0002,  1, 0, 1'b0, 4'h6});
    vecs.push_back('{16'h0004,  1, 0, 1'b0, 4'h6});
    vecs.push_back('{16'h0004,  1, 1, 1'b1, 4'h2});
    vecs.push_back('{16'h0000,  2, 0, 1'b0, 4'h2});
`endif

    rst_n = 1'b0;
    held  = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_col", {28'h0, col_n}, 32'hE);
    chk("rst_key", {28'h0, key}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_pressed", {31'h0, pressed}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ec;
      @(negedge clk);
      ec = ~(4'b0001 << (((i + 1) / 4) % 4));
      chk($sformatf("free_col%0d", i), {28'h0, col_n}, {28'h0, ec});
      chk($sformatf("free_out%0d", i),
          {26'h0, key, valid, pressed}, 32'h0);
    end

    align();
    foreach (vecs[i]) run_vec(vecs[i], i);

    for (int i = 0; i < 10; i++) begin
      held = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (16) @(negedge clk);
      #1;
      chk($sformatf("toggle%0d", i), {31'h0, pressed}, 32'h0);
    end

    held = 16'h0200;
    repeat (16) @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    held  = 16'h0;
    #1;
    chk("mid_rst_col", {28'h0, col_n}, 32'hE);
    chk("mid_rst_key", {28'h0, key}, 32'h0);
    chk("mid_rst_valid", {31'h0, valid}, 32'h0);
    chk("mid_rst_pressed", {31'h0, pressed}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_col0", {28'h0, col_n}, 32'hE);
    repeat (4) @(negedge clk);
    chk("restart_col1", {28'h0, col_n}, 32'hD);
    repeat (60) @(negedge clk);
    #1;
    chk("post_rst_pressed", {31'h0, pressed}, 32'h0);
    chk("post_rst_key", {28'h0, key}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
